// File: rtl/axil_reg_stat_counters.sv
`default_nettype none
// ============================================================================
// Module      : axil_reg_stat_counters
// Description : Read-only bank of event counters on a register read port,
//               with low-word snapshot for 64-bit counters.
// Revision    : 1.0
// ============================================================================
module axil_reg_stat_counters #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int CNT_COUNT     = 8,
  parameter int CNT_WIDTH     = 64,
  parameter int INC_WIDTH     = 1,
  parameter int BASE_ADDR     = 0,
  parameter bit CLEAR_ON_READ = 1'b0,
  parameter bit SATURATE      = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CNT_COUNT*INC_WIDTH-1:0] event_inc,
  input  logic                           cnt_clear,
  input  logic [ADDR_WIDTH-1:0]          reg_rd_addr,
  input  logic                           reg_rd_en,
  output logic [DATA_WIDTH-1:0]          reg_rd_data,
  output logic                           reg_rd_wait,
  output logic                           reg_rd_ack
);

  localparam int C_WIN_BYTES = CNT_COUNT * CNT_WIDTH / 8;
  localparam int C_IDX_W     = (CNT_COUNT > 1) ? $clog2(CNT_COUNT) : 1;
  localparam logic [ADDR_WIDTH:0] C_BASE = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] C_END  = (ADDR_WIDTH+1)'(BASE_ADDR + C_WIN_BYTES);

  logic [ADDR_WIDTH:0]     w_addr_ext;
  logic [ADDR_WIDTH:0]     w_offset;
  logic                    w_hit;
  logic                    w_accept;
  logic                    w_is_hi;
  logic [C_IDX_W-1:0]      w_idx;
  logic [CNT_WIDTH-1:0]    w_cnt [CNT_COUNT];
  logic [CNT_WIDTH-1:0]    w_sel;
  logic [DATA_WIDTH-1:0]   w_lo_word;
  logic [DATA_WIDTH-1:0]   w_hi_word;
  logic [DATA_WIDTH-1:0]   w_rd_value;
  logic                    w_unused;

  logic                    r_ack;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH-1:0]   r_shadow;
  logic [C_IDX_W-1:0]      r_shadow_idx;

  assign w_addr_ext = {1'b0, reg_rd_addr};
  assign w_offset   = w_addr_ext - C_BASE;
  assign w_hit      = (w_addr_ext >= C_BASE) && (w_addr_ext < C_END);
  assign w_accept   = reg_rd_en && !r_ack && w_hit;
  assign w_unused   = ^w_offset;

  generate
    if (CNT_WIDTH == 64) begin : g_w64
      assign w_idx     = w_offset[C_IDX_W+2:3];
      assign w_is_hi   = w_offset[2];
      assign w_lo_word = w_sel[31:0];
      assign w_hi_word = w_sel[63:32];
    end else begin : g_w32
      assign w_idx     = w_offset[C_IDX_W+1:2];
      assign w_is_hi   = 1'b0;
      assign w_lo_word = w_sel[31:0];
      assign w_hi_word = '0;
    end
  endgenerate

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < CNT_COUNT; i++) begin
      if (w_idx == C_IDX_W'(i)) w_sel = w_cnt[i];
    end
  end

  // High word comes from the snapshot only when it belongs to the same counter.
  assign w_rd_value = w_is_hi ? ((r_shadow_idx == w_idx) ? r_shadow : w_hi_word)
                              : w_lo_word;

  generate
    for (genvar gi = 0; gi < CNT_COUNT; gi++) begin : g_cnt
      logic [INC_WIDTH-1:0] w_inc;
      logic [CNT_WIDTH:0]   w_inc_ext;
      logic [CNT_WIDTH:0]   w_sum;
      logic                 w_rd_clr;
      logic [CNT_WIDTH-1:0] r_cnt;

      assign w_inc     = event_inc[gi*INC_WIDTH +: INC_WIDTH];
      assign w_inc_ext = (CNT_WIDTH+1)'(w_inc);
      assign w_sum     = {1'b0, r_cnt} + w_inc_ext;
      assign w_rd_clr  = CLEAR_ON_READ && w_accept && !w_is_hi && (w_idx == C_IDX_W'(gi));

      // Clearing reloads with this cycle's increment so no event is dropped.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (cnt_clear || w_rd_clr) begin
          r_cnt <= w_inc_ext[CNT_WIDTH-1:0];
        end else if (SATURATE && w_sum[CNT_WIDTH]) begin
          r_cnt <= '1;
        end else begin
          r_cnt <= w_sum[CNT_WIDTH-1:0];
        end
      end

      assign w_cnt[gi] = r_cnt;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack        <= 1'b0;
      r_data       <= '0;
      r_shadow     <= '0;
      r_shadow_idx <= '0;
    end else begin
      r_ack  <= w_accept;
      r_data <= w_accept ? w_rd_value : '0;
      if (w_accept && !w_is_hi) begin
        r_shadow     <= w_hi_word;
        r_shadow_idx <= w_idx;
      end
    end
  end

  assign reg_rd_data = r_data;
  assign reg_rd_ack  = r_ack;
  assign reg_rd_wait = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_stat_counters.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_reg_stat_counters
// Description : Directed bench for the statistics counter register bank.
// Revision    : 1.0
// ============================================================================
module tb_axil_reg_stat_counters;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cnt_clear = 1'b0;
  logic [15:0]  addr = '0;
  logic [255:0] inc   [4];
  logic         en    [4];
  logic [31:0]  rdata [4];
  logic         ack   [4];
  logic         rwait [4];
  int           ack_cnt [4] = '{default: 0};
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  // 0: 64-bit saturating, 1: 64-bit clear-on-read, 2: 32-bit saturating, 3: 32-bit wrapping
  axil_reg_stat_counters #(.CNT_WIDTH(64), .INC_WIDTH(32), .CLEAR_ON_READ(1'b0), .SATURATE(1'b1)) dut0 (
    .clk(clk), .rst(rst), .event_inc(inc[0]), .cnt_clear(cnt_clear), .reg_rd_addr(addr),
    .reg_rd_en(en[0]), .reg_rd_data(rdata[0]), .reg_rd_wait(rwait[0]), .reg_rd_ack(ack[0]));
  axil_reg_stat_counters #(.CNT_WIDTH(64), .INC_WIDTH(32), .CLEAR_ON_READ(1'b1), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .event_inc(inc[1]), .cnt_clear(cnt_clear), .reg_rd_addr(addr),
    .reg_rd_en(en[1]), .reg_rd_data(rdata[1]), .reg_rd_wait(rwait[1]), .reg_rd_ack(ack[1]));
  axil_reg_stat_counters #(.CNT_WIDTH(32), .INC_WIDTH(32), .CLEAR_ON_READ(1'b0), .SATURATE(1'b1)) dut2 (
    .clk(clk), .rst(rst), .event_inc(inc[2]), .cnt_clear(cnt_clear), .reg_rd_addr(addr),
    .reg_rd_en(en[2]), .reg_rd_data(rdata[2]), .reg_rd_wait(rwait[2]), .reg_rd_ack(ack[2]));
  axil_reg_stat_counters #(.CNT_WIDTH(32), .INC_WIDTH(32), .CLEAR_ON_READ(1'b0), .SATURATE(1'b0)) dut3 (
    .clk(clk), .rst(rst), .event_inc(inc[3]), .cnt_clear(cnt_clear), .reg_rd_addr(addr),
    .reg_rd_en(en[3]), .reg_rd_data(rdata[3]), .reg_rd_wait(rwait[3]), .reg_rd_ack(ack[3]));

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 4; d++) if (ack[d]) ack_cnt[d]++;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic do_read(input int d, input logic [15:0] a, output logic [31:0] data,
                         output bit acked, output int lat);
    @(negedge clk);
    addr = a; en[d] = 1'b1; acked = 1'b0; data = '0; lat = -1;
    for (int k = 0; k < 3 && !acked; k++) begin
      @(posedge clk); #1;
      if (ack[d]) begin acked = 1'b1; data = rdata[d]; lat = k; end
    end
    en[d] = 1'b0;
  endtask

  task automatic rd_chk(input int d, input logic [15:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] v; bit ak; int lat;
    do_read(d, a, v, ak, lat);
    chk({nm, "_ack"}, 64'(ak), 64'd1);
    chk(nm, 64'(v), 64'(exp));
  endtask

  task automatic bump(input int d, input int i, input logic [31:0] amt);
    @(negedge clk);
    inc[d][i*32 +: 32] = amt;
    @(posedge clk); #1;
    inc[d][i*32 +: 32] = '0;
  endtask

  typedef struct { logic [15:0] addr; logic [31:0] exp; } vec_t;
  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v; bit ak; int lat; int base;
    for (int d = 0; d < 4; d++) begin inc[d] = '0; en[d] = 1'b0; end

    // counters after preload: c0=5 c1=0 c2=0x2_0000_0000 c3=0 c5=0x12345678 c7=0x1_FFFF_FFFE
    tbl[0] = '{16'h0000, 32'h0000_0005};
    tbl[1] = '{16'h0004, 32'h0000_0000};
    tbl[2] = '{16'h0028, 32'h1234_5678};
    tbl[3] = '{16'h002C, 32'h0000_0000};
    tbl[4] = '{16'h0038, 32'hFFFF_FFFE};
    tbl[5] = '{16'h003C, 32'h0000_0001};
    tbl[6] = '{16'h0010, 32'h0000_0000};
    tbl[7] = '{16'h0014, 32'h0000_0002};
    tbl[8] = '{16'h0030, 32'h0000_0000};
    tbl[9] = '{16'h003C, 32'h0000_0001};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 64'(ack[0]), 64'd0);
    chk("rst_data", 64'(rdata[0]), 64'd0);
    for (int d = 0; d < 4; d++) chk($sformatf("wait%0d", d), 64'(rwait[d]), 64'd0);
    @(negedge clk); rst = 1'b0;

    // reset arriving while a read is pending
    bump(0, 0, 32'd3);
    bump(0, 3, 32'd9);
    base = ack_cnt[0];
    @(negedge clk); addr = 16'h0000; en[0] = 1'b1;
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 chk("rst_mid_ack", 64'(ack[0]), 64'd0);
    @(negedge clk); en[0] = 1'b0; rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk("rst_mid_nack", 64'(ack_cnt[0] - base), 64'd0);
    rd_chk(0, 16'h0000, 32'd0, "rst_cnt0");
    rd_chk(0, 16'h0018, 32'd0, "rst_cnt3");

    // five single-cycle events, latency-1 read
    @(negedge clk); inc[0][31:0] = 32'd1;
    repeat (5) @(posedge clk);
    #1 inc[0][31:0] = '0;
    do_read(0, 16'h0000, v, ak, lat);
    chk("c0_ack", 64'(ak), 64'd1);
    chk("c0_data", 64'(v), 64'd5);
    chk("c0_lat", 64'(lat), 64'd0);

    // low-word snapshot versus live high word
    bump(0, 2, 32'hFFFF_FFFF);
    bump(0, 2, 32'hFFFF_FFFF);
    bump(0, 2, 32'd1);
    rd_chk(0, 16'h0010, 32'hFFFF_FFFF, "c2_lo");
    bump(0, 2, 32'd1);
    rd_chk(0, 16'h0014, 32'd1, "c2_hi_shadow");
    rd_chk(0, 16'h0018, 32'd0, "c3_lo");
    rd_chk(0, 16'h0014, 32'd2, "c2_hi_live");

    bump(0, 5, 32'h1234_5678);
    bump(0, 7, 32'hFFFF_FFFF);
    bump(0, 7, 32'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) rd_chk(0, tbl[i].addr, tbl[i].exp, $sformatf("tbl%0d", i));

    // clear-on-read with a coincident increment
    bump(1, 1, 32'd7);
    @(negedge clk); addr = 16'h0008; en[1] = 1'b1; inc[1][63:32] = 32'd1;
    @(posedge clk); #1;
    inc[1][63:32] = '0;
    chk("cor_ack", 64'(ack[1]), 64'd1);
    chk("cor_data", 64'(rdata[1]), 64'd7);
    en[1] = 1'b0;
    rd_chk(1, 16'h0008, 32'd1, "cor_after");
    rd_chk(1, 16'h0008, 32'd0, "cor_cleared");
    bump(1, 1, 32'd5);
    rd_chk(1, 16'h000C, 32'd0, "cor_hi");
    rd_chk(1, 16'h0008, 32'd5, "cor_hi_noclr");

    // 32-bit saturate versus wrap
    bump(2, 0, 32'hFFFF_FFFE);
    bump(2, 0, 32'd3);
    rd_chk(2, 16'h0000, 32'hFFFF_FFFF, "sat32");
    bump(3, 0, 32'hFFFF_FFFE);
    bump(3, 0, 32'd3);
    rd_chk(3, 16'h0000, 32'd1, "wrap32");
    bump(2, 7, 32'd9);
    rd_chk(2, 16'h001C, 32'd9, "c32_top");
    do_read(2, 16'h0020, v, ak, lat);
    chk("c32_miss_ack", 64'(ak), 64'd0);

    // out-of-window hold and in-window hold across the ack cycle
    base = ack_cnt[0];
    do_read(0, 16'h0040, v, ak, lat);
    repeat (2) @(posedge clk);
    #2 chk("miss_acks", 64'(ack_cnt[0] - base), 64'd0);
    base = ack_cnt[0];
    @(negedge clk); addr = 16'h0000; en[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); en[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("held_acks", 64'(ack_cnt[0] - base), 64'd1);

    // global clear keeps the snapshot and the coincident increment
    rd_chk(0, 16'h0038, 32'hFFFF_FFFE, "pre_clr_lo");
    @(negedge clk); cnt_clear = 1'b1; inc[0][31:0] = 32'd4;
    @(posedge clk); #1;
    cnt_clear = 1'b0; inc[0][31:0] = '0;
    rd_chk(0, 16'h003C, 32'd1, "clr_shadow_kept");
    rd_chk(0, 16'h0000, 32'd4, "clr_inc_kept");
    rd_chk(0, 16'h0028, 32'd0, "clr_c5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
